// File: rtl/readout_ctrl.sv
// Column readout sequencer: exposes the array, then strobes the column shift register
// and streams one sampled pixel per column over valid/ready.
module readout_ctrl #(
  parameter int N_COLS        = 4,
  parameter int DATA_W        = 8,
  parameter int EXPOSE_CYCLES = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDX_W         = $clog2(N_COLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              expose,
  output logic              read,
  input  logic [N_COLS-1:0] col_sel,
  input  logic [DATA_W-1:0] pix_data,
  output logic [DATA_W-1:0] data_out,
  output logic [IDX_W-1:0]  col_idx,
  output logic              valid,
  input  logic              ready,
  output logic              frame_done,
  output logic              err
);

  localparam int CNT_MAX = (EXPOSE_CYCLES > SETTLE_CYCLES) ? EXPOSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_EXPOSE, S_READ, S_SETTLE, S_SAMPLE, S_OUTPUT, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   col;
  logic [N_COLS-1:0]  col_exp;
  logic               expose_end, settle_end, last_col, accept;

  assign expose_end = (cnt == CNT_W'(EXPOSE_CYCLES - 1));
  assign settle_end = (cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign last_col   = (col == IDX_W'(N_COLS - 1));
  assign accept     = valid && ready;
  assign col_exp    = N_COLS'(1) << col;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_EXPOSE;
      S_EXPOSE: if (expose_end) state_nxt = S_READ;
      S_READ:   state_nxt = S_SETTLE;
      S_SETTLE: if (settle_end) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = S_OUTPUT;
      S_OUTPUT: if (accept) state_nxt = last_col ? S_DONE : S_READ;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      // cnt restarts whenever the state changes, so it times the current dwell
      if (state_nxt != state) cnt <= '0;
      else if (state == S_EXPOSE || state == S_SETTLE) cnt <= cnt + 1'b1;
      if (state == S_IDLE && start) col <= '0;
      else if (state == S_OUTPUT && accept && !last_col) col <= col + 1'b1;
    end
  end

  // Outputs are flops decoded from the next state so they line up with the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      expose     <= 1'b0;
      read       <= 1'b0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      data_out   <= '0;
      col_idx    <= '0;
    end else begin
      busy       <= (state_nxt != S_IDLE);
      expose     <= (state_nxt == S_EXPOSE);
      read       <= (state_nxt == S_READ);
      valid      <= (state_nxt == S_OUTPUT);
      frame_done <= (state_nxt == S_DONE);
      if (state == S_IDLE && start) err <= 1'b0;
      else if (state == S_SAMPLE && col_sel != col_exp) err <= 1'b1;
      if (state == S_SAMPLE) begin
        data_out <= pix_data;
        col_idx  <= col;
      end
    end
  end

endmodule

// File: doc/readout_ctrl.md
Name: readout_ctrl

Overview:
Column readout sequencer for the pixel array; sits directly upstream of the shiftReg column-select shift register.
- Runs an exposure window, then issues one-cycle `read` strobes that advance the shift register's one-hot column select.
- After each strobe and a settle period, samples pixel data and presents it on a valid/ready stream to the downstream frame buffer.

Parameters:
- N_COLS, 4, number of columns; equals the shift-register output width.
- DATA_W, 8, pixel data width.
- EXPOSE_CYCLES, 16, clock cycles `expose` is held high per frame (≥1).
- SETTLE_CYCLES, 2, wait cycles between a `read` strobe and sampling (≥1).
- IDX_W, $clog2(N_COLS), column index width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  frame start request; sampled only in IDLE.
- busy  output  1  high in every state except IDLE.
- expose  output  1  pixel exposure enable.
- read  output  1  one-cycle strobe to the shift register `read` input.
- col_sel  input  N_COLS  one-hot column select returned by the shift register (`out`).
- pix_data  input  DATA_W  analog-front-end data for the selected column.
- data_out  output  DATA_W  sampled pixel value.
- col_idx  output  IDX_W  column index of `data_out`.
- valid  output  1  `data_out`/`col_idx` valid.
- ready  input  1  downstream accepts the word when valid&&ready.
- frame_done  output  1  one-cycle pulse at end of frame.
- err  output  1  sticky error flag; cleared only by reset or the next accepted `start`.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; column counter 0.
- Reset is asynchronous at any time, including mid-frame. It forces IDLE immediately, drops `valid`, and loses any pending word.
- All outputs are registered. They are decoded from the state and counters that are in place after each clock edge.
- IDLE:
  - `start`=1 → EXPOSE on the next edge, column counter ← 0, `err` ← 0.
  - `start` in any other state is ignored.
- EXPOSE: `expose`=1 for exactly EXPOSE_CYCLES cycles, then READ.
- READ: `read`=1 for exactly one cycle, then SETTLE.
- SETTLE: exactly SETTLE_CYCLES cycles, then SAMPLE.
- SAMPLE (one cycle):
  - `data_out` ← `pix_data`.
  - `col_idx` ← column counter.
  - `err` ← 1 if `col_sel` ≠ (1 << column counter). This covers not one-hot, zero, or wrong position.
  - Next state OUTPUT.
  - A sampling error does not stop the frame.
- OUTPUT:
  - `valid`=1; `data_out` and `col_idx` are held stable until the handshake completes.
  - On valid&&ready: `valid` deasserts on the next cycle.
  - If column counter = N_COLS−1 → DONE; otherwise column counter +1 → READ.
  - `ready` high while `valid` is low has no effect.
  - Back-pressure of any length is allowed; no `read` is issued while waiting.
- DONE: `frame_done`=1 for one cycle, then IDLE. `busy` falls on the same edge that enters IDLE.
- Frame length with `ready` held high: 1 + EXPOSE_CYCLES + N_COLS·(1 + SETTLE_CYCLES + 1 + 1) + 1 cycles from the `start` edge to the edge that returns to IDLE. With defaults this is 38.
- Column counter is IDX_W bits and never wraps within a frame. The DONE transition occurs before any increment past N_COLS−1.
- Exactly N_COLS `read` strobes and N_COLS accepted words are produced per frame.

Test Plan:
1. Reset, then `start` for one cycle, `ready`=1, ideal shift-register model (col_sel 0001, 0010, 0100, 1000 after successive reads), `pix_data`=8'h10+column → `expose` high 16 cycles; 4 `read` pulses spaced 5 cycles apart; words (0,8'h10), (1,8'h11), (2,8'h12), (3,8'h13); `frame_done` pulse at cycle 38; `err`=0.
2. Same as 1 but `ready` low for 7 cycles on column 2 → `valid` held, `data_out`=8'h12 stable throughout, no `read` during the stall, frame completes 7 cycles later.
3. Model returns `col_sel`=4'b0011 at column 1 → `err` set at the column-1 SAMPLE and stays 1; frame still completes; the next `start` clears `err`.
4. `start` pulsed during EXPOSE and during OUTPUT → ignored; exactly 4 words and one `frame_done`.
5. `reset` asserted asynchronously mid-cycle while in SETTLE of column 2 → all outputs 0 immediately; a new `start` runs a full clean frame from column 0.
6. `start` held high continuously → back-to-back frames; IDLE lasts exactly one cycle between frames; each frame yields 4 words.
